// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle a - b - bin, one Sklansky-carry nibble per clock
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx;

    logic [IW+1:0]    shamt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [3:0]       c;
    logic             cout;
    logic             g10, p10, g32, p32, g20, p20, g30, p30;
    logic [3:0]       slice;
    logic [WIDTH-1:0] slice_mask;
    logic [WIDTH-1:0] diff_next;

    assign shamt = {idx, 2'b00};
    assign a_sh  = a_q >> shamt;
    assign b_sh  = b_q >> shamt;

    // Subtraction as a + ~b + ~bin: b is inverted before generate/propagate.
    assign p = a_sh[3:0] ^ ~b_sh[3:0];
    assign g = a_sh[3:0] & ~b_sh[3:0];

    // Sklansky prefix tree: pairs first, then each upper group folds in the 1:0 group.
    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g20 = g[2] | (p[2] & g10);
    assign p20 = p[2] & p10;
    assign g30 = g32 | (p32 & g10);
    assign p30 = p32 & p10;

    assign c[0] = carry_q;
    assign c[1] = g[0] | (p[0] & carry_q);
    assign c[2] = g10 | (p10 & carry_q);
    assign c[3] = g20 | (p20 & carry_q);
    assign cout = g30 | (p30 & carry_q);

    assign slice      = p ^ c;
    assign slice_mask = {{(WIDTH-4){1'b0}}, 4'hF} << shamt;
    assign diff_next  = (diff & ~slice_mask) | (WIDTH'(slice) << shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ~bin;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    diff    <= diff_next;
                    carry_q <= cout;
                    idx     <= idx + 1'b1;
                    if (idx == IW'(N - 1)) begin
                        bout  <= ~cout;
                        zero  <= (diff_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed and random checks of nibble_serial_subtractor
module tb_nibble_serial_subtractor;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    int n_cmp  = 0;
    int n_fail = 0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, diff, bout, zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%0b done=%0b diff=%h bout=%0b zero=%0b, want all 0",
                     busy, done, diff, bout, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_release: got busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

    task automatic test_arith();
        logic [15:0] va [6] = '{16'h1234, 16'h0000, 16'h1000, 16'h8000, 16'h0005, 16'hFFFF};
        logic [15:0] vb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'h7FFF, 16'h0005, 16'hFFFF};
        logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] vd [6] = '{16'h1000, 16'hFFFF, 16'h0FFF, 16'h0000, 16'hFFFF, 16'h0000};
        logic        vo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        vz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            a = va[v]; b = vb[v]; bin = vc[v]; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 1; i <= N; i++) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if ({busy, done} !== ((i < N) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL arith%0d_timing_c%0d: got busy=%0b done=%0b", v, i, busy, done);
                end
            end
            n_cmp++;
            if ({diff, bout, zero} !== {vd[v], vo[v], vz[v]}) begin
                n_fail++;
                $display("FAIL arith%0d_result: got diff=%h bout=%0b zero=%0b, want diff=%h bout=%0b zero=%0b",
                         v, diff, bout, zero, vd[v], vo[v], vz[v]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, done, diff} !== {2'b00, vd[v]}) begin
                n_fail++;
                $display("FAIL arith%0d_hold: got busy=%0b done=%0b diff=%h, want 0 0 %h",
                         v, busy, done, diff, vd[v]);
            end
        end
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        a = 16'h00FF; b = 16'h000F; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        for (int i = 2; i <= N + 2; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n_cmp++;
            if ({busy, done} !== ((i < N) ? 2'b10 : (i == N) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL ignored_start_timing_c%0d: got busy=%0b done=%0b", i, busy, done);
            end
            if (i == N) begin
                n_cmp++;
                if ({diff, bout, zero} !== {16'h00F0, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL ignored_start_result: got diff=%h bout=%0b zero=%0b, want 00f0 0 0",
                             diff, bout, zero);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, diff, bout, zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%0b done=%0b diff=%h bout=%0b zero=%0b, want all 0",
                     busy, done, diff, bout, zero);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_done_c%0d: got done=%0b, want 0", i, done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= N; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({busy, done} !== ((i < N) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL post_reset_timing_c%0d: got busy=%0b done=%0b", i, busy, done);
            end
        end
        n_cmp++;
        if ({diff, bout, zero} !== {16'h000F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_result: got diff=%h bout=%0b zero=%0b, want 000f 0 0", diff, bout, zero);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        @(negedge clk);
        a = 16'h0003; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        n_cmp++;
        if ({done, diff, bout} !== {1'b1, 16'h0002, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%0b diff=%h bout=%0b, want 1 0002 0", done, diff, bout);
        end
        a = 16'h0001; b = 16'h0003; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%0b done=%0b, want 1 0", busy, done);
        end
        gap = 0;
        while (done !== 1'b1 && gap < 10) begin
            @(posedge clk);
            #1;
            gap++;
        end
        n_cmp++;
        if (gap !== N) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d cycles after accept, want %0d", gap, N);
        end
        n_cmp++;
        if ({diff, bout, zero} !== {16'hFFFE, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: got diff=%h bout=%0b zero=%0b, want fffe 1 0", diff, bout, zero);
        end
    endtask

    task automatic test_random();
        logic [WIDTH:0]   ref_full;
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        for (int n = 0; n < 10000; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            ref_full = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rc};
            @(negedge clk);
            a = ra; b = rb; bin = rc; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 1; i <= N; i++) begin
                @(posedge clk);
                #1;
                n_cmp++;
                if ({busy, done} !== ((i < N) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rand%0d_timing_c%0d: got busy=%0b done=%0b", n, i, busy, done);
                end
            end
            n_cmp++;
            if ({diff, bout, zero} !== {ref_full[WIDTH-1:0], ref_full[WIDTH], ref_full[WIDTH-1:0] == '0}) begin
                n_fail++;
                $display("FAIL rand%0d_result a=%h b=%h bin=%0b: got diff=%h bout=%0b zero=%0b, want diff=%h bout=%0b",
                         n, ra, rb, rc, diff, bout, zero, ref_full[WIDTH-1:0], ref_full[WIDTH]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
